// File: rtl/cipher_feeder.sv
// FIFO-buffered sequencer feeding the cipher: one new_message/key cycle per message, then one byte per cycle.
// Optional `CIPHER_FEEDER_LEVEL_EN adds a registered fifo_level output.
module cipher_feeder #(
   parameter int DEPTH = 16,
   parameter int DW    = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sop,
   input  logic [DW-1:0] in_key,
   input  logic [DW-1:0] in_data,
   output logic          new_message,
   output logic [DW-1:0] key,
   output logic [DW-1:0] data_in,
   output logic          valid_in,
   output logic          err_orphan
`ifdef CIPHER_FEEDER_LEVEL_EN
   ,
   output logic [AW:0]   fifo_level
`endif
);

   localparam int EW = 2*DW + 1;

   typedef enum logic [1:0] {S_IDLE, S_NEWMSG, S_STREAM} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [EW-1:0]   r_mem [DEPTH];
   logic [AW:0]     r_wr_ptr;
   logic [AW:0]     r_rd_ptr;
   logic            r_init;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_head_sop;
   logic [DW-1:0]   w_head_key;
   logic [DW-1:0]   w_head_data;

   logic            r_new_message;
   logic            r_valid_in;
   logic            r_err_orphan;
   logic [DW-1:0]   r_key;
   logic [DW-1:0]   r_data_in;
   logic            w_new_message_next;
   logic            w_valid_in_next;
   logic            w_err_orphan_next;
   logic [DW-1:0]   w_key_next;
   logic [DW-1:0]   w_data_in_next;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign in_ready = r_init & ~w_full;
   assign w_push   = in_valid & in_ready;

   assign {w_head_sop, w_head_key, w_head_data} = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {in_sop, in_key, in_data};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_init   <= 1'b0;
      end else begin
         r_init <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

`ifdef CIPHER_FEEDER_LEVEL_EN
   logic [AW:0] r_level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_level <= '0;
      end else begin
         r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

   assign fifo_level = r_level;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_new_message <= 1'b0;
         r_valid_in    <= 1'b0;
         r_err_orphan  <= 1'b0;
         r_key         <= '0;
         r_data_in     <= '0;
      end else begin
         r_state       <= w_state_next;
         r_new_message <= w_new_message_next;
         r_valid_in    <= w_valid_in_next;
         r_err_orphan  <= w_err_orphan_next;
         r_key         <= w_key_next;
         r_data_in     <= w_data_in_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (!w_empty && w_head_sop) w_state_next = S_NEWMSG;
         S_NEWMSG: w_state_next = S_STREAM;
         S_STREAM: if (!w_empty && w_head_sop) w_state_next = S_NEWMSG;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // The sop entry stays at the head through the new_message cycle and is popped as data byte 0.
   always_comb begin
      w_pop              = 1'b0;
      w_new_message_next = 1'b0;
      w_valid_in_next    = 1'b0;
      w_err_orphan_next  = r_err_orphan;
      w_key_next         = r_key;
      w_data_in_next     = r_data_in;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               if (w_head_sop) begin
                  w_new_message_next = 1'b1;
                  w_key_next         = w_head_key;
               end else begin
                  w_pop             = 1'b1;
                  w_err_orphan_next = 1'b1;
               end
            end
         end
         S_NEWMSG: begin
            w_pop           = 1'b1;
            w_data_in_next  = w_head_data;
            w_valid_in_next = 1'b1;
         end
         S_STREAM: begin
            if (!w_empty) begin
               if (w_head_sop) begin
                  w_new_message_next = 1'b1;
                  w_key_next         = w_head_key;
               end else begin
                  w_pop           = 1'b1;
                  w_data_in_next  = w_head_data;
                  w_valid_in_next = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   assign new_message = r_new_message;
   assign valid_in    = r_valid_in;
   assign err_orphan  = r_err_orphan;
   assign key         = r_key;
   assign data_in     = r_data_in;

endmodule

// File: tb/tb_cipher_feeder.sv
// Bench for cipher_feeder: an event-queue model of the expected cipher-side stream plus directed timing checks.
module tb_cipher_feeder;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic       in_sop;
   logic [7:0] in_key;
   logic [7:0] in_data;
   logic       new_message;
   logic [7:0] key;
   logic [7:0] data_in;
   logic       valid_in;
   logic       err_orphan;

   int n_pass  = 0;
   int n_total = 0;

   // Expected events in order: {1,key} for a new_message cycle, {0,data} for a data byte.
   logic [8:0]  exp_q[$];
   bit          in_msg  = 1'b0;
   bit          exp_err = 1'b0;
   // Per-cycle record: [17] new_message, [16] valid_in, [15:8] key, [7:0] data_in.
   logic [17:0] trace[$];

   cipher_feeder #(.DEPTH(16), .DW(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sop      (in_sop),
      .in_key      (in_key),
      .in_data     (in_data),
      .new_message (new_message),
      .key         (key),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .err_orphan  (err_orphan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Compare outputs against the model, then record any host byte that will be accepted at the next edge.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!reset) begin
         trace.push_back({new_message, valid_in, key, data_in});
         chk("nm_vi_overlap", 32'(new_message & valid_in), 32'(0));
         if (new_message) begin
            chk("nm_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("new_message_key", 32'({1'b1, key}), 32'(e));
            end
         end
         if (valid_in) begin
            chk("data_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("data_in_byte", 32'({1'b0, data_in}), 32'(e));
            end
         end
         if (in_valid && in_ready) begin
            if (in_sop) begin
               exp_q.push_back({1'b1, in_key});
               exp_q.push_back({1'b0, in_data});
               in_msg = 1'b1;
            end else if (in_msg) begin
               exp_q.push_back({1'b0, in_data});
            end else begin
               exp_err = 1'b1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send(input logic sop, input logic [7:0] k, input logic [7:0] d);
      in_valid = 1'b1;
      in_sop   = sop;
      in_key   = k;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      exp_q.delete();
      in_msg   = 1'b0;
      exp_err  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk(name, 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      int  acc;
      int  cycles;
      int  j;
      int  bub;
      int  nm_cnt;
      int  hits;
      bit  saw_full;
      logic r;

      reset    = 1'b1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_key   = 8'h00;
      in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_new_message", 32'(new_message), 32'(0));
      chk("rst_valid_in", 32'(valid_in), 32'(0));
      chk("rst_err_orphan", 32'(err_orphan), 32'(0));
      chk("rst_key", 32'(key), 32'(0));
      chk("rst_data_in", 32'(data_in), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready_after_release", 32'(in_ready), 32'(1));

      // Test 1: cycle-exact latency of the first message.
      in_valid = 1'b1; in_sop = 1'b1; in_key = 8'h2B; in_data = 8'h00;
      @(posedge clk); #1;
      in_sop = 1'b0; in_key = 8'h00; in_data = 8'h11;
      @(posedge clk); #1;
      chk("t1_nm_after_e1", 32'(new_message), 32'(1));
      chk("t1_key_after_e1", 32'(key), 32'h2B);
      chk("t1_vi_low_after_e1", 32'(valid_in), 32'(0));
      in_data = 8'h22;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t1_byte0", 32'({new_message, valid_in, data_in}), 32'({2'b01, 8'h00}));
      @(posedge clk); #1;
      chk("t1_byte1", 32'({new_message, valid_in, data_in}), 32'({2'b01, 8'h11}));
      @(posedge clk); #1;
      chk("t1_byte2", 32'({new_message, valid_in, data_in}), 32'({2'b01, 8'h22}));
      @(posedge clk); #1;
      chk("t1_idle_hold", 32'({valid_in, data_in, key}), 32'({1'b0, 8'h22, 8'h2B}));
      drain("t1_drained");

      // Test 2: single-byte messages arrive faster than they drain, so the FIFO must fill.
      acc = 0; cycles = 0; saw_full = 1'b0;
      in_valid = 1'b1;
      while (acc < 40 && cycles < 300) begin
         in_sop  = 1'b1;
         in_key  = 8'(8'h80 + acc);
         in_data = 8'(acc);
         @(negedge clk);
         r = in_ready;
         if (!r) saw_full = 1'b1;
         @(posedge clk); #1;
         if (r) acc++;
         cycles++;
      end
      in_valid = 1'b0;
      chk("t2_in_ready_dropped", 32'(saw_full), 32'(1));
      chk("t2_accepted", 32'(acc), 32'(40));
      drain("t2_drained");

      // Test 3: back-to-back messages separated by exactly one new_message cycle.
      trace.delete();
      send(1'b1, 8'h01, 8'hA0); send(1'b0, 8'h00, 8'hA1); send(1'b0, 8'h00, 8'hA2);
      send(1'b1, 8'h02, 8'hB0); send(1'b0, 8'h00, 8'hB1);
      in_valid = 1'b0;
      drain("t3_drained");
      j = -1;
      foreach (trace[i]) if (trace[i][16] && trace[i][7:0] == 8'hA2) j = i;
      chk("t3_found_a2", 32'(j >= 0), 32'(1));
      if (j >= 0 && j + 2 < trace.size()) begin
         chk("t3_gap_cycle", 32'({trace[j+1][17], trace[j+1][16], trace[j+1][15:8]}), 32'({2'b10, 8'h02}));
         chk("t3_b_first", 32'({trace[j+2][16], trace[j+2][7:0]}), 32'({1'b1, 8'hB0}));
      end

      // Test 4: orphan byte is dropped and flagged; the following message is intact.
      do_reset();
      trace.delete();
      send(1'b0, 8'h00, 8'h55);
      send(1'b1, 8'h33, 8'h60); send(1'b0, 8'h00, 8'h61);
      in_valid = 1'b0;
      drain("t4_drained");
      chk("t4_model_err", 32'(exp_err), 32'(1));
      chk("t4_err_orphan", 32'(err_orphan), 32'(1));
      hits = 0;
      foreach (trace[i]) if (trace[i][16] && trace[i][7:0] == 8'h55) hits++;
      chk("t4_no_orphan_data", 32'(hits), 32'(0));
      repeat (5) @(posedge clk);
      #1;
      chk("t4_err_sticky", 32'(err_orphan), 32'(1));

      // Test 5: three idle host cycles mid-message. The new_message cycle leaves one byte
      // queued, so the cipher side sees two bubbles.
      trace.delete();
      send(1'b1, 8'h44, 8'h70); send(1'b0, 8'h00, 8'h71);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      send(1'b0, 8'h00, 8'h72); send(1'b0, 8'h00, 8'h73);
      in_valid = 1'b0;
      drain("t5_drained");
      j = -1;
      foreach (trace[i]) if (trace[i][16] && trace[i][7:0] == 8'h71) j = i;
      chk("t5_found_71", 32'(j >= 0), 32'(1));
      if (j >= 0) begin
         bub = 0; nm_cnt = 0;
         while (j + 1 + bub < trace.size() && !trace[j+1+bub][16]) begin
            if (trace[j+1+bub][17]) nm_cnt++;
            bub++;
         end
         chk("t5_bubbles", 32'(bub), 32'(2));
         chk("t5_no_nm", 32'(nm_cnt), 32'(0));
         if (j + 1 + bub < trace.size())
            chk("t5_resume_byte", 32'(trace[j+1+bub][7:0]), 32'h72);
      end

      // Test 6: asynchronous reset mid-stream discards everything.
      do_reset();
      send(1'b1, 8'h5A, 8'h80);
      for (int k = 1; k < 8; k++) send(1'b0, 8'h00, 8'(8'h80 + k));
      in_valid = 1'b0;
      reset = 1'b1;
      exp_q.delete();
      in_msg = 1'b0;
      exp_err = 1'b0;
      #1;
      chk("t6_async_outputs", 32'({new_message, valid_in, err_orphan, key, data_in}), 32'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("t6_in_ready", 32'(in_ready), 32'(1));
      trace.delete();
      repeat (10) @(posedge clk);
      #1;
      hits = 0;
      foreach (trace[i]) if (trace[i][16] || trace[i][17]) hits++;
      chk("t6_no_stale", 32'(hits), 32'(0));
      send(1'b1, 8'h77, 8'h90); send(1'b0, 8'h00, 8'h91);
      in_valid = 1'b0;
      drain("t6_drained");
      chk("t6_key_held", 32'(key), 32'h77);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
